wf_play_seq: RTL
================

Name: wf_play_seq

Overview:
- Playback sequencer for the waveform DPBRAM.
- On a start request it fetches waveform points 0..N-1 at a programmable sample period and presents each point as a setpoint with a valid strobe.
- It repeats the table a programmed number of times, then reports completion.
- It also arbitrates the host (xintf) write path: host writes are granted only while no playback is running, so the table cannot change mid-waveform.

Parameters:
- ADDR_W, 10, DPBRAM address width; the table holds up to 2^ADDR_W points.
- DATA_W, 16, waveform point width.
- RAM_LAT, 1, DPBRAM read latency in clocks (1 or 2).
- MIN_PERIOD, 4, minimum clocks per sample; smaller programmed periods are clamped up to this.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-low reset.
- i_start  in  1  level; a rising edge in IDLE launches playback.
- i_stop  in  1  synchronous abort, active high.
- i_point_num  in  ADDR_W+1  points per waveform pass (1..2^ADDR_W); 0 is invalid.
- i_period  in  32  clocks per sample.
- i_repeat  in  16  number of passes; 0 means loop until i_stop.
- o_ram_addr  out  ADDR_W  DPBRAM read address.
- o_ram_en  out  1  DPBRAM read enable, one-cycle pulse per point.
- i_ram_dout  in  DATA_W  DPBRAM read data, valid RAM_LAT clocks after o_ram_en.
- o_wf_data  out  DATA_W  current setpoint; holds its value between samples.
- o_wf_valid  out  1  one-cycle pulse when o_wf_data updates.
- o_busy  out  1  high while playback is active.
- o_done  out  1  high from normal completion until the next launch.
- o_err  out  1  sticky invalid-configuration flag, cleared by the next valid launch.
- o_pass_cnt  out  16  number of completed passes.
- i_host_wr_req  in  1  host wants to write the table.
- o_host_wr_gnt  out  1  write grant to the host write path.

Behaviour:
- Reset (i_rst low, asynchronous): FSM goes to IDLE. All outputs are 0; o_ram_addr=0, o_wf_data=0, o_pass_cnt=0. The start edge detector is cleared, so a start held high through reset does not launch; it must fall and rise again.
- States: IDLE, LOAD, FETCH, WAIT, HOLD, DONE.
- IDLE:
  - On a start rising edge with i_point_num==0: set o_err=1 and stay in IDLE.
  - On a start rising edge with a valid count: go to LOAD. The launch is blocked while a host write is granted and i_host_wr_req is still high.
- LOAD (1 clk):
  - Latch point_num, period_eff = max(i_period, MIN_PERIOD), and repeat.
  - Clear o_done, o_err, o_pass_cnt and the address counter. Set o_busy=1.
  - Configuration inputs are ignored until the next launch.
- FETCH (1 clk): o_ram_en=1, o_ram_addr=addr. Restart the period counter (count 0 = the FETCH cycle).
- WAIT (RAM_LAT clks): on the last WAIT cycle, register i_ram_dout into o_wf_data and pulse o_wf_valid on the following clock. Valid therefore appears RAM_LAT+1 clocks after the o_ram_en pulse.
- HOLD: runs until the period counter reaches period_eff-1, then:
  - If addr != point_num-1: addr+1, go to FETCH. The sample spacing is exactly period_eff clocks.
  - If it is the last point: o_pass_cnt+1 (saturating at 0xFFFF).
    - If repeat!=0 and the new pass count equals repeat: go to DONE.
    - Otherwise: addr=0, go to FETCH.
- DONE: o_busy=0, o_done=1, o_ram_addr=0. Go to IDLE next clock; o_done stays high in IDLE until the next LOAD.
- i_stop: has priority over every transition in LOAD, FETCH, WAIT and HOLD.
  - Go to IDLE immediately with o_busy=0 and o_done=0.
  - o_wf_data keeps its last value. A pending valid for an in-flight read is suppressed.
- Arbiter:
  - o_host_wr_gnt = i_host_wr_req when the FSM is in IDLE or DONE; otherwise 0.
  - The grant is registered, so it rises 1 clk after the request and drops in the same clock the FSM leaves IDLE. Launch blocking prevents that case from arising.
- Simultaneous start edge and host request in IDLE: the host wins. The start edge is discarded, not queued.
- Address counter: ADDR_W bits. With point_num=2^ADDR_W it wraps from max to 0 at the end of the pass.
- Period counter: 32 bits, no overflow, because period_eff <= 2^32-1.

Test Plan:
- Point_num=4, period=10, repeat=1, RAM holds 0x100..0x103 → o_ram_en at addr 0..3 spaced 10 clks; o_wf_valid 2 clks after each en (RAM_LAT=1); data 0x100..0x103; o_done=1 after the 4th HOLD; o_pass_cnt=1.
- Period=2 → clamped; valid strobes are spaced exactly 4 clks apart.
- Repeat=0, point_num=3 → addresses cycle 0,1,2,0,1,2,…; o_pass_cnt increments every 3 samples. i_stop during WAIT → o_busy=0 next clk, no o_wf_valid, o_done=0, o_wf_data holds its last value.
- Point_num=0 start → o_err=1, o_busy stays 0. A following valid start clears o_err.
- Host request held high in IDLE → o_host_wr_gnt=1; start edge while granted is ignored. Request during playback → grant stays 0 until DONE, then rises 1 clk after entering DONE.
- Assert i_rst mid-HOLD with i_start held high → all outputs 0; no relaunch after release until i_start toggles low then high.

Source files
------------

// File: rtl/wf_play_seq.sv
// Waveform playback sequencer: walks the DPBRAM table at a programmable sample
// period, repeats it N times, and fences host table writes while playing.
module wf_play_seq #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int RAM_LAT    = 1,
  parameter int MIN_PERIOD = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W:0]   i_point_num,
  input  logic [31:0]       i_period,
  input  logic [15:0]       i_repeat,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_en,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic [DATA_W-1:0] o_wf_data,
  output logic              o_wf_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_pass_cnt,
  input  logic              i_host_wr_req,
  output logic              o_host_wr_gnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t        state;
  logic          start_q;
  logic [ADDR_W:0] pn_q;
  logic [31:0]   per_q;
  logic [15:0]   rep_q;
  logic [31:0]   pcnt;

  logic          start_rise;
  logic          last_pt;
  logic          per_end;
  logic          lat_end;
  logic [15:0]   pass_nxt;
  logic [31:0]   per_eff;

  assign start_rise = i_start & ~start_q;
  assign last_pt    = ({1'b0, o_ram_addr} == pn_q - 1'b1);
  assign per_end    = (pcnt == per_q - 32'd1);
  // pcnt counts from the FETCH cycle, so it doubles as the read-latency counter
  assign lat_end    = (pcnt == 32'(RAM_LAT));
  assign pass_nxt   = (&o_pass_cnt) ? o_pass_cnt : o_pass_cnt + 16'd1;
  assign per_eff    = (i_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : i_period;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      // start_q resets high so a start held through reset needs a fresh edge
      start_q       <= 1'b1;
      pn_q          <= '0;
      per_q         <= '0;
      rep_q         <= '0;
      pcnt          <= '0;
      o_ram_addr    <= '0;
      o_ram_en      <= 1'b0;
      o_wf_data     <= '0;
      o_wf_valid    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_pass_cnt    <= '0;
      o_host_wr_gnt <= 1'b0;
    end else begin
      start_q       <= i_start;
      o_ram_en      <= 1'b0;
      o_wf_valid    <= 1'b0;
      o_host_wr_gnt <= i_host_wr_req && (state == S_IDLE || state == S_DONE);

      if (i_stop && (state == S_LOAD || state == S_FETCH ||
                     state == S_WAIT || state == S_HOLD)) begin
        state  <= S_IDLE;
        o_busy <= 1'b0;
        o_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // a host request swallows the start edge, granted or not yet
            if (start_rise && !i_host_wr_req) begin
              if (i_point_num == '0) begin
                o_err <= 1'b1;
              end else begin
                state      <= S_LOAD;
                pn_q       <= i_point_num;
                per_q      <= per_eff;
                rep_q      <= i_repeat;
                o_done     <= 1'b0;
                o_err      <= 1'b0;
                o_pass_cnt <= '0;
                o_ram_addr <= '0;
                o_busy     <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            state    <= S_FETCH;
            o_ram_en <= 1'b1;
            pcnt     <= '0;
          end
          S_FETCH: begin
            state <= S_WAIT;
            pcnt  <= pcnt + 32'd1;
          end
          S_WAIT: begin
            pcnt <= pcnt + 32'd1;
            if (lat_end) begin
              o_wf_data  <= i_ram_dout;
              o_wf_valid <= 1'b1;
              state      <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (per_end) begin
              if (!last_pt) begin
                o_ram_addr <= o_ram_addr + 1'b1;
                state      <= S_FETCH;
                o_ram_en   <= 1'b1;
                pcnt       <= '0;
              end else begin
                o_pass_cnt <= pass_nxt;
                o_ram_addr <= '0;
                if (rep_q != '0 && pass_nxt == rep_q) begin
                  state  <= S_DONE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                end else begin
                  state    <= S_FETCH;
                  o_ram_en <= 1'b1;
                  pcnt     <= '0;
                end
              end
            end else begin
              pcnt <= pcnt + 32'd1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
